bcd_to_seg_dec: RTL and testbench

//  Registered binary-to-packed-BCD converter: 4-bit unsigned code in, two BCD

---
 rtl/bcd_to_seg_dec.sv | 77 +++++++
 tb/tb_bcd_to_seg_dec.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_seg_dec.sv
// Purpose: registered binary-to-packed-BCD converter for display digit drivers.
// Latency: one core clock cycle from an in_valid sample to seg/out_valid.
// Backpressure: none; a result is produced every cycle in_valid is high.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears seg and out_valid at once
//   in_valid   bcd is sampled on the clock edge where this is high
//   bcd        IN_W-bit unsigned binary value to convert
//   seg        NDIG packed BCD digits, digit k at seg[4k+3:4k], k=0 is units
//   out_valid  high for one cycle when seg carries a freshly converted value
module bcd_to_seg_dec #(
  parameter int IN_W = 4,
  parameter int NDIG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     bcd,
  output logic [4*NDIG-1:0]   seg,
  output logic                out_valid
);

  localparam int SEG_W = 4 * NDIG;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int j = 0; j < n; j++) begin
      p = p * 10;
    end
    return p;
  endfunction

  localparam longint MAX_IN  = (longint'(1) <<< IN_W) - 1;
  localparam longint MAX_OUT = pow10(NDIG);

  // The digit count has to cover the largest input value, otherwise the
  // top digit would silently wrap.
  generate
    if (MAX_OUT <= MAX_IN) begin : g_bad_params
      $error("bcd_to_seg_dec: NDIG=%0d digits cannot represent %0d", NDIG, MAX_IN);
    end
  endgenerate

  // Shift-add-3: before each shift any digit >= 5 gets +3 so the shift
  // carries it cleanly into the next digit. Digits beyond the value's
  // magnitude never reach 5, so they stay zero.
  logic [SEG_W-1:0] conv;

  always_comb begin
    conv = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      for (int k = 0; k < NDIG; k++) begin
        if (conv[4*k +: 4] >= 4'd5) begin
          conv[4*k +: 4] = conv[4*k +: 4] + 4'd3;
        end
      end
      conv = {conv[SEG_W-2:0], bcd[i]};
    end
  end

  // seg only loads on a valid sample, so an undriven bcd while idle cannot
  // disturb the displayed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        seg <= conv;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_seg_dec.sv
// Purpose: self-checking bench for bcd_to_seg_dec (default and 7-bit/3-digit).
// Latency: expects each result one cycle after its sample.
// Backpressure: none exercised; the DUT has no downstream handshake.
module tb_bcd_to_seg_dec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  bcd;
  logic [7:0]  seg;
  logic        out_valid;

  logic        in2_valid;
  logic [6:0]  bcd2;
  logic [11:0] seg2;
  logic        out2_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_q[$];
  logic [11:0] exp2_q[$];

  bcd_to_seg_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .bcd       (bcd),
    .seg       (seg),
    .out_valid (out_valid)
  );

  bcd_to_seg_dec #(.IN_W(7), .NDIG(3)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in2_valid),
    .bcd       (bcd2),
    .seg       (seg2),
    .out_valid (out2_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: plain divide/modulo, digit by digit.
  function automatic logic [7:0] model2(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [11:0] model3(input int v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Drive inputs on the falling edge, record the expected result, and
  // return just after the sampling rising edge.
  task automatic drive_edge(input logic v, input logic [3:0] b);
    @(negedge clk);
    in_valid = v;
    bcd      = b;
    if (v) exp_q.push_back(model2(int'(b)));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wide(input logic v, input logic [6:0] b);
    @(negedge clk);
    in2_valid = v;
    bcd2      = b;
    if (v) exp2_q.push_back(model3(int'(b)));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_state;
    n_cmp++;
    if (seg !== 8'h00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: seg=%h out_valid=%b required seg=00 out_valid=0", seg, out_valid);
    end
    n_cmp++;
    if (seg2 !== 12'h000 || out2_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state_wide: seg=%h out_valid=%b required seg=000 out_valid=0", seg2, out2_valid);
    end
  endtask

  task automatic test_reset_async;
    logic [7:0] e;
    drive_edge(1'b1, 4'd15);
    e = exp_q.pop_front();
    n_cmp++;
    if (seg !== e || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL preload_15: seg=%h out_valid=%b required seg=%h out_valid=1", seg, out_valid, e);
    end
    // Mid-cycle reset, well away from any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seg !== 8'h00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: seg=%h out_valid=%b required seg=00 out_valid=0", seg, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep;
    logic [7:0] e;
    for (int v = 0; v < 16; v++) begin
      drive_edge(1'b1, 4'(v));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sweep_queue: empty scoreboard at v=%0d", v);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (seg !== e || out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL sweep_%0d: seg=%h out_valid=%b required seg=%h out_valid=1", v, seg, out_valid, e);
        end
      end
    end
  endtask

  task automatic test_boundaries;
    logic [3:0] pts [3];
    logic [7:0] req [3];
    logic [7:0] e;
    pts[0] = 4'd9;  req[0] = 8'h09;
    pts[1] = 4'd10; req[1] = 8'h10;
    pts[2] = 4'd15; req[2] = 8'h15;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 4'd0);
      drive_edge(1'b1, pts[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (seg !== req[i] || seg !== e || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL boundary_%0d: seg=%h out_valid=%b required seg=%h out_valid=1", pts[i], seg, out_valid, req[i]);
      end
    end
  endtask

  task automatic test_hold;
    logic [7:0] e;
    drive_edge(1'b1, 4'd12);
    e = exp_q.pop_front();
    n_cmp++;
    if (seg !== e || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_load: seg=%h out_valid=%b required seg=%h out_valid=1", seg, out_valid, e);
    end
    drive_edge(1'b0, 4'd3);
    n_cmp++;
    if (seg !== 8'h12 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_idle: seg=%h out_valid=%b required seg=12 out_valid=0", seg, out_valid);
    end
    drive_edge(1'b0, 4'bxxxx);
    n_cmp++;
    if (seg !== 8'h12 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_x_input: seg=%h out_valid=%b required seg=12 out_valid=0", seg, out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] e;
    drive_edge(1'b1, 4'd5);
    e = exp_q.pop_front();
    n_cmp++;
    if (seg !== e || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midstream_5: seg=%h out_valid=%b required seg=%h out_valid=1", seg, out_valid, e);
    end
    // Present 6 and pulse reset across its sampling edge; 6 must be lost.
    @(negedge clk);
    in_valid = 1'b1;
    bcd      = 4'd6;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seg !== 8'h00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_reset: seg=%h out_valid=%b required seg=00 out_valid=0", seg, out_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (seg !== 8'h00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_6_ignored: seg=%h out_valid=%b required seg=00 out_valid=0", seg, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (seg !== 8'h00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_post_release: seg=%h out_valid=%b required seg=00 out_valid=0", seg, out_valid);
    end
    drive_edge(1'b1, 4'd7);
    e = exp_q.pop_front();
    n_cmp++;
    if (seg !== e || seg !== 8'h07 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midstream_7: seg=%h out_valid=%b required seg=07 out_valid=1", seg, out_valid);
    end
    drive_edge(1'b0, 4'd0);
  endtask

  task automatic test_wide;
    logic [6:0]  pts [5];
    logic [11:0] e;
    pts[0] = 7'd127; pts[1] = 7'd99; pts[2] = 7'd100; pts[3] = 7'd0; pts[4] = 7'd58;
    for (int i = 0; i < 5; i++) begin
      drive_wide(1'b1, pts[i]);
      e = exp2_q.pop_front();
      n_cmp++;
      if (seg2 !== e || out2_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL wide_%0d: seg=%h out_valid=%b required seg=%h out_valid=1", pts[i], seg2, out2_valid, e);
      end
    end
    drive_wide(1'b0, 7'd1);
    n_cmp++;
    if (seg2 !== 12'h058 || out2_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_hold: seg=%h out_valid=%b required seg=058 out_valid=0", seg2, out2_valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bcd       = 4'd0;
    in2_valid = 1'b0;
    bcd2      = 7'd0;
    #22;
    test_reset_state();
    rst_n = 1'b1;
    test_reset_async();
    test_sweep();
    test_boundaries();
    test_hold();
    test_reset_midstream();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
